// File: rtl/axi4_rd_arbiter_2to1.sv
// axi4_rd_arbiter_2to1
//   Two-requester AXI4 read-channel arbiter with a single outstanding burst downstream.
//   States: idle -> addr (AR forwarded) -> data (R forwarded) -> idle.
//   Ports:
//     CLK, nRST                 clock and synchronous active-low reset
//     S0_AR*/S1_AR*             requester read-address channels (payload, VALID in, READY out)
//     S0_R*/S1_R*               requester read-data channels (payload, VALID out, READY in)
//     M_AR*, M_R*               shared downstream address/data channels
//     GRANT                     index of the current or most recently granted requester
//     PROT_ERR                  sticky burst-length mismatch flag (cleared only by reset)
//   Build option: define ARB_FIXED_PRIORITY_EN for fixed S0 priority; round-robin otherwise.

module axi4_rd_arbiter_2to1 #(
    parameter int unsigned C_THREAD_ID_WIDTH = 1,
    parameter int unsigned C_ADDR_WIDTH      = 32,
    parameter int unsigned C_DATA_WIDTH      = 128,
    parameter int unsigned C_USE_AXI4        = 1,
    localparam int unsigned LenW             = (C_USE_AXI4 != 0) ? 8 : 4
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [C_THREAD_ID_WIDTH-1:0] S0_ARID,
    input  logic [C_ADDR_WIDTH-1:0]      S0_ARADDR,
    input  logic [LenW-1:0]              S0_ARLEN,
    input  logic [2:0]                   S0_ARSIZE,
    input  logic [1:0]                   S0_ARBURST,
    input  logic                         S0_ARVALID,
    output logic                         S0_ARREADY,
    output logic [C_THREAD_ID_WIDTH-1:0] S0_RID,
    output logic [C_DATA_WIDTH-1:0]      S0_RDATA,
    output logic [1:0]                   S0_RRESP,
    output logic                         S0_RLAST,
    output logic                         S0_RVALID,
    input  logic                         S0_RREADY,
    input  logic [C_THREAD_ID_WIDTH-1:0] S1_ARID,
    input  logic [C_ADDR_WIDTH-1:0]      S1_ARADDR,
    input  logic [LenW-1:0]              S1_ARLEN,
    input  logic [2:0]                   S1_ARSIZE,
    input  logic [1:0]                   S1_ARBURST,
    input  logic                         S1_ARVALID,
    output logic                         S1_ARREADY,
    output logic [C_THREAD_ID_WIDTH-1:0] S1_RID,
    output logic [C_DATA_WIDTH-1:0]      S1_RDATA,
    output logic [1:0]                   S1_RRESP,
    output logic                         S1_RLAST,
    output logic                         S1_RVALID,
    input  logic                         S1_RREADY,
    output logic [C_THREAD_ID_WIDTH-1:0] M_ARID,
    output logic [C_ADDR_WIDTH-1:0]      M_ARADDR,
    output logic [LenW-1:0]              M_ARLEN,
    output logic [2:0]                   M_ARSIZE,
    output logic [1:0]                   M_ARBURST,
    output logic                         M_ARVALID,
    input  logic                         M_ARREADY,
    input  logic [C_THREAD_ID_WIDTH-1:0] M_RID,
    input  logic [C_DATA_WIDTH-1:0]      M_RDATA,
    input  logic [1:0]                   M_RRESP,
    input  logic                         M_RLAST,
    input  logic                         M_RVALID,
    output logic                         M_RREADY,
    output logic                         GRANT,
    output logic                         PROT_ERR
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e     state_q, state_d;
    logic       grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic       prot_err_q, prot_err_d;

    logic       winner;
    logic       g_rready;
    logic       in_addr;
    logic       in_data;

    // Handshake outputs are gated by nRST so they read 0 during a reset cycle.
    assign in_addr  = nRST && (state_q == StAddr);
    assign in_data  = nRST && (state_q == StData);
    assign g_rready = grant_q ? S1_RREADY : S0_RREADY;

`ifdef ARB_FIXED_PRIORITY_EN
    assign winner = S0_ARVALID ? 1'b0 : 1'b1;
`else
    // Both requesting: the one not granted last wins; otherwise the only requester wins.
    assign winner = (S0_ARVALID && S1_ARVALID) ? ~grant_q : S1_ARVALID;
`endif

    // Address channel: granted payload passes straight through.
    assign M_ARID     = grant_q ? S1_ARID    : S0_ARID;
    assign M_ARADDR   = grant_q ? S1_ARADDR  : S0_ARADDR;
    assign M_ARLEN    = grant_q ? S1_ARLEN   : S0_ARLEN;
    assign M_ARSIZE   = grant_q ? S1_ARSIZE  : S0_ARSIZE;
    assign M_ARBURST  = grant_q ? S1_ARBURST : S0_ARBURST;
    assign M_ARVALID  = in_addr;
    assign S0_ARREADY = in_addr && !grant_q && M_ARREADY;
    assign S1_ARREADY = in_addr &&  grant_q && M_ARREADY;

    // Data channel: payload is broadcast, only VALID is steered to the granted port.
    assign S0_RID    = M_RID;
    assign S0_RDATA  = M_RDATA;
    assign S0_RRESP  = M_RRESP;
    assign S0_RLAST  = M_RLAST;
    assign S1_RID    = M_RID;
    assign S1_RDATA  = M_RDATA;
    assign S1_RRESP  = M_RRESP;
    assign S1_RLAST  = M_RLAST;
    assign S0_RVALID = in_data && !grant_q && M_RVALID;
    assign S1_RVALID = in_data &&  grant_q && M_RVALID;
    assign M_RREADY  = in_data && g_rready;

    assign GRANT    = grant_q;
    assign PROT_ERR = prot_err_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        prot_err_d = prot_err_q;
        unique case (state_q)
            StIdle: begin
                if (S0_ARVALID || S1_ARVALID) begin
                    grant_d = winner;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (M_ARREADY) begin
                    cnt_d   = 8'(M_ARLEN);
                    state_d = StData;
                end
            end
            StData: begin
                if (M_RVALID && g_rready) begin
                    if (M_RLAST) begin
                        if (cnt_q != 8'd0) prot_err_d = 1'b1;
                        state_d = StIdle;
                    end else if (cnt_q == 8'd0) begin
                        // Extra beat beyond ARLEN: flag it and hold the counter at 0.
                        prot_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= StIdle;
            grant_q    <= 1'b1;
            cnt_q      <= 8'd0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            prot_err_q <= prot_err_d;
        end
    end

endmodule

// File: tb/tb_axi4_rd_arbiter_2to1.sv
// Bench for axi4_rd_arbiter_2to1: requester drivers, a simple AXI slave, a transaction-level
// model compared against the DUT on every falling edge, and directed scenarios with literal
// expectations.

module tb_axi4_rd_arbiter_2to1;

    localparam int IW = 1;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int LW = 8;

    logic          CLK, nRST;
    logic [IW-1:0] S0_ARID, S1_ARID, S0_RID, S1_RID, M_ARID, M_RID;
    logic [AW-1:0] S0_ARADDR, S1_ARADDR, M_ARADDR;
    logic [LW-1:0] S0_ARLEN, S1_ARLEN, M_ARLEN;
    logic [2:0]    S0_ARSIZE, S1_ARSIZE, M_ARSIZE;
    logic [1:0]    S0_ARBURST, S1_ARBURST, M_ARBURST;
    logic          S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY, M_ARVALID, M_ARREADY;
    logic [DW-1:0] S0_RDATA, S1_RDATA, M_RDATA;
    logic [1:0]    S0_RRESP, S1_RRESP, M_RRESP;
    logic          S0_RLAST, S1_RLAST, M_RLAST;
    logic          S0_RVALID, S1_RVALID, M_RVALID;
    logic          S0_RREADY, S1_RREADY, M_RREADY;
    logic          GRANT, PROT_ERR;

    axi4_rd_arbiter_2to1 u_dut (
        .CLK(CLK), .nRST(nRST),
        .S0_ARID(S0_ARID), .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARSIZE(S0_ARSIZE),
        .S0_ARBURST(S0_ARBURST), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RID(S0_RID), .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST),
        .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
        .S1_ARID(S1_ARID), .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARSIZE(S1_ARSIZE),
        .S1_ARBURST(S1_ARBURST), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RID(S1_RID), .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST),
        .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .GRANT(GRANT), .PROT_ERR(PROT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester drivers ----------------
    int            s_rem [2];
    logic [AW-1:0] s_addr [2];
    logic [LW-1:0] s_len [2];

    initial begin
        S0_ARVALID = 0; S1_ARVALID = 0;
        S0_ARID = 1'b0; S1_ARID = 1'b1;
        S0_ARSIZE = 3'd4; S1_ARSIZE = 3'd4; S0_ARBURST = 2'b01; S1_ARBURST = 2'b01;
        S0_ARADDR = '0; S1_ARADDR = '0; S0_ARLEN = '0; S1_ARLEN = '0;
        forever begin
            @(negedge CLK);
            if (S0_ARVALID && S0_ARREADY && s_rem[0] > 0) s_rem[0]--;
            if (S1_ARVALID && S1_ARREADY && s_rem[1] > 0) s_rem[1]--;
            @(posedge CLK);
            #1;
            S0_ARVALID = (s_rem[0] > 0); S0_ARADDR = s_addr[0]; S0_ARLEN = s_len[0];
            S1_ARVALID = (s_rem[1] > 0); S1_ARADDR = s_addr[1]; S1_ARLEN = s_len[1];
        end
    end

    // ---------------- downstream slave ----------------
    bit            bfm_arready_en = 1'b1;
    bit            early_last = 1'b0;
    bit            bfm_active = 1'b0;
    int            bfm_idx = 0;
    int            bfm_len = 0;
    logic [AW-1:0] bfm_addr = '0;
    logic [IW-1:0] bfm_id = '0;

    initial begin
        M_ARREADY = 0; M_RVALID = 0; M_RLAST = 0; M_RDATA = '0; M_RID = '0; M_RRESP = '0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                bfm_active = 1'b0;
            end else begin
                if (M_RVALID && M_RREADY) begin
                    if (M_RLAST) bfm_active = 1'b0;
                    else bfm_idx++;
                end
                if (M_ARVALID && M_ARREADY) begin
                    bfm_active = 1'b1; bfm_idx = 0; bfm_len = int'(M_ARLEN);
                    bfm_addr = M_ARADDR; bfm_id = M_ARID;
                end
            end
            @(posedge CLK);
            #1;
            M_ARREADY = bfm_arready_en;
            M_RVALID  = bfm_active;
            M_RDATA   = DW'(bfm_addr) + DW'(bfm_idx);
            M_RID     = bfm_id;
            M_RLAST   = bfm_active && (early_last || bfm_idx == bfm_len);
        end
    end

    // ---------------- model + per-cycle compare ----------------
    localparam int PhIdle = 0, PhAddr = 1, PhData = 2;
    int            m_phase = PhIdle;
    bit            m_grant = 1'b1;
    bit            m_err = 1'b0;
    int            m_len = 0;
    int            m_seen = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            glog[$];

    initial begin
        logic exp_ar, exp_r, g_rr;
        forever begin
            @(negedge CLK);
            if (S0_RVALID && S0_RREADY) q0.push_back(S0_RDATA);
            if (S1_RVALID && S1_RREADY) q1.push_back(S1_RDATA);
            if (M_ARVALID && M_ARREADY) glog.push_back(int'(GRANT));
            exp_ar = nRST && (m_phase == PhAddr);
            exp_r  = nRST && (m_phase == PhData);
            g_rr   = m_grant ? S1_RREADY : S0_RREADY;
            if (chk_en) begin
                check("m_arvalid", M_ARVALID, exp_ar);
                check("s0_arready", S0_ARREADY, exp_ar && !m_grant && M_ARREADY);
                check("s1_arready", S1_ARREADY, exp_ar && m_grant && M_ARREADY);
                check("m_rready", M_RREADY, exp_r && g_rr);
                check("s0_rvalid", S0_RVALID, exp_r && !m_grant && M_RVALID);
                check("s1_rvalid", S1_RVALID, exp_r && m_grant && M_RVALID);
                check("grant", GRANT, m_grant);
                check("prot_err", PROT_ERR, m_err);
                if (exp_ar) begin
                    check("m_araddr", M_ARADDR, m_grant ? S1_ARADDR : S0_ARADDR);
                    check("m_arlen", M_ARLEN, m_grant ? S1_ARLEN : S0_ARLEN);
                    check("m_arid", M_ARID, m_grant ? S1_ARID : S0_ARID);
                end
                if (exp_r && M_RVALID) begin
                    check("sx_rdata", m_grant ? S1_RDATA : S0_RDATA, M_RDATA);
                    check("sx_rlast", m_grant ? S1_RLAST : S0_RLAST, M_RLAST);
                end
            end
            // Advance to the state that follows the coming rising edge.
            if (!nRST) begin
                m_phase = PhIdle; m_grant = 1'b1; m_err = 1'b0; m_len = 0; m_seen = 0;
            end else if (m_phase == PhIdle) begin
                if (S0_ARVALID || S1_ARVALID) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    m_grant = !S0_ARVALID;
`else
                    if (S0_ARVALID && S1_ARVALID) m_grant = !m_grant;
                    else m_grant = S1_ARVALID;
`endif
                    m_phase = PhAddr;
                end
            end else if (m_phase == PhAddr) begin
                if (M_ARREADY) begin
                    m_len = int'(m_grant ? S1_ARLEN : S0_ARLEN);
                    m_seen = 0;
                    m_phase = PhData;
                end
            end else if (M_RVALID && g_rr) begin
                // Burst carries m_len+1 beats; the last must be the one with RLAST.
                if (M_RLAST) begin
                    if (m_seen != m_len) m_err = 1'b1;
                    m_phase = PhIdle;
                end else begin
                    if (m_seen >= m_len) m_err = 1'b1;
                    m_seen++;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input string name);
        int stable = 0;
        int k = 0;
        while (stable < 3 && k < 500) begin
            @(negedge CLK);
            k++;
            if (m_phase == PhIdle && s_rem[0] == 0 && s_rem[1] == 0 && !bfm_active && !M_RVALID)
                stable++;
            else
                stable = 0;
        end
        check(name, stable >= 3, 1'b1);
    endtask

    task automatic wait_beats(input int port, input int n, input string name);
        int k = 0;
        while (((port == 0) ? q0.size() : q1.size()) < n && k < 200) begin
            @(posedge CLK);
            k++;
        end
        check(name, ((port == 0) ? q0.size() : q1.size()) >= n, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int exp_order [6];
        int k;
        logic exp_g;
        logic [AW-1:0] exp_a;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
        exp_g = 1'b0; exp_a = 32'h5000;
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
        exp_g = 1'b1; exp_a = 32'h6000;
`endif
        s_rem[0] = 0; s_rem[1] = 0;
        s_addr[0] = '0; s_addr[1] = '0; s_len[0] = '0; s_len[1] = '0;
        S0_RREADY = 1'b1; S1_RREADY = 1'b1;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        check("reset_grant", GRANT, 1'b1);
        check("reset_prot_err", PROT_ERR, 1'b0);
        check("reset_m_arvalid", M_ARVALID, 1'b0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Simultaneous requests, three single-beat bursts each.
        glog.delete();
        @(posedge CLK); #1;
        s_addr[0] = 32'h2000; s_addr[1] = 32'h3000; s_len[0] = 8'd0; s_len[1] = 8'd0;
        s_rem[0] = 3; s_rem[1] = 3;
        wait_idle("rr_idle");
        check("rr_count", glog.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), glog[i], exp_order[i]);

        // Lone S0 burst, ARLEN=3.
        q0.delete(); q1.delete();
        s_addr[0] = 32'h1000; s_len[0] = 8'd3;
        @(posedge CLK); #1;
        s_rem[0] = 1;
        k = 0;
        do begin @(negedge CLK); k++; end while (!S0_ARVALID && k < 10);
        check("single_arvalid_lat0", M_ARVALID, 1'b0);
        @(negedge CLK);
        check("single_arvalid_lat1", M_ARVALID, 1'b1);
        check("single_araddr", M_ARADDR, 32'h1000);
        check("single_arlen", M_ARLEN, 8'd3);
        wait_idle("single_idle");
        check("single_beats", q0.size(), 4);
        check("single_s1_beats", q1.size(), 0);
        for (int i = 0; i < 4 && i < q0.size(); i++)
            check($sformatf("single_data_%0d", i), q0[i], 128'h1000 + i);

        // RREADY stall of 5 cycles after the first beat.
        q0.delete();
        s_addr[0] = 32'h4000; s_len[0] = 8'd3;
        @(posedge CLK); #1;
        s_rem[0] = 1;
        wait_beats(0, 1, "stall_first_beat");
        #1;
        S0_RREADY = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            check("stall_m_rready", M_RREADY, 1'b0);
            check("stall_data_held", S0_RDATA, 128'h4001);
        end
        @(posedge CLK); #1;
        S0_RREADY = 1'b1;
        wait_idle("stall_idle");
        check("stall_beats", q0.size(), 4);
        for (int i = 0; i < 4 && i < q0.size(); i++)
            check($sformatf("stall_data_%0d", i), q0[i], 128'h4000 + i);

        // ARREADY held low for 10 cycles while both requesters wait.
        bfm_arready_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        s_addr[0] = 32'h5000; s_addr[1] = 32'h6000; s_len[0] = 8'd0; s_len[1] = 8'd0;
        s_rem[0] = 1; s_rem[1] = 1;
        k = 0;
        do begin @(negedge CLK); k++; end while (!M_ARVALID && k < 10);
        repeat (10) begin
            @(negedge CLK);
            check("arstall_arvalid", M_ARVALID, 1'b1);
            check("arstall_grant", GRANT, exp_g);
            check("arstall_araddr", M_ARADDR, exp_a);
        end
        @(posedge CLK); #1;
        bfm_arready_en = 1'b1;
        wait_idle("arstall_idle");

        // Early RLAST on an ARLEN=1 burst.
        q1.delete();
        check("pre_prot_err", PROT_ERR, 1'b0);
        early_last = 1'b1;
        s_addr[1] = 32'h7000; s_len[1] = 8'd1;
        @(posedge CLK); #1;
        s_rem[1] = 1;
        wait_beats(1, 1, "early_beat");
        @(negedge CLK);
        check("early_prot_err", PROT_ERR, 1'b1);
        wait_idle("early_idle");
        early_last = 1'b0;
        check("early_prot_sticky", PROT_ERR, 1'b1);
        check("early_beats", q1.size(), 1);

        // Reset during beat 2 of an ARLEN=7 burst.
        q0.delete();
        s_addr[0] = 32'h8000; s_len[0] = 8'd7;
        @(posedge CLK); #1;
        s_rem[0] = 1;
        wait_beats(0, 2, "rst_two_beats");
        #1;
        nRST = 1'b0;
        @(negedge CLK);
        check("rstcyc_m_rready", M_RREADY, 1'b0);
        check("rstcyc_s0_rvalid", S0_RVALID, 1'b0);
        check("rstcyc_m_arvalid", M_ARVALID, 1'b0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check("postrst_grant", GRANT, 1'b1);
        check("postrst_prot_err", PROT_ERR, 1'b0);
        check("postrst_s0_rvalid", S0_RVALID, 1'b0);
        check("postrst_m_rready", M_RREADY, 1'b0);
        wait_idle("postrst_idle");
        check("postrst_beats", q0.size(), 2);

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_rd_arbiter_2to1.md
AXI4_RD_ARBITER_2TO1 -- requirements
Module: axi4_rd_arbiter_2to1

Interface
REQ-001 SHALL have parameter C_THREAD_ID_WIDTH, default 1, meaning the width of ARID/RID.
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 32, meaning the width of ARADDR.
REQ-003 SHALL have parameter C_DATA_WIDTH, default 128, meaning the width of RDATA.
REQ-004 SHALL have parameter C_USE_AXI4, default 1, meaning ARLEN is 8 bits when set and 4 bits (AXI3) when clear.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port nRST, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have ports Sn_ARID/ARADDR/ARLEN/ARSIZE/ARBURST (n=0,1), input, parameter widths with ARSIZE 3 and ARBURST 2: requester read-address payload.
REQ-008 SHALL have ports Sn_ARVALID input 1 and Sn_ARREADY output 1: requester address handshake.
REQ-009 SHALL have ports Sn_RID/RDATA/RRESP/RLAST/RVALID, output, parameter widths with RRESP 2: requester read data.
REQ-010 SHALL have port Sn_RREADY, input, 1 bit: requester read-data ready.
REQ-011 SHALL have ports M_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID output and M_ARREADY input: shared downstream address channel to the AXI4 slave BFM.
REQ-012 SHALL have ports M_RID/RDATA/RRESP/RLAST/RVALID input and M_RREADY output: shared downstream read-data channel.
REQ-013 SHALL have port GRANT, output, 1 bit: index of the current/last granted requester.
REQ-014 SHALL have port PROT_ERR, output, 1 bit: sticky flag for a burst-length mismatch.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA; only one burst is outstanding downstream at any time.
REQ-016 In IDLE, when any Sn_ARVALID=1, SHALL latch the winner into GRANT and enter ADDR on the next edge; an IDLE cycle with no requests SHALL hold state.
REQ-017 With both requesters valid in IDLE, SHALL grant the requester not granted last (round-robin); GRANT SHALL reset to 1 so that S0 wins first.
REQ-018 In ADDR, M_ARVALID SHALL be 1 and M_AR* SHALL pass the granted Sx_AR* combinationally.
REQ-019 In ADDR, Sx_ARREADY of the granted port SHALL equal M_ARREADY; the other port's ARREADY SHALL be 0.
REQ-020 An ADDR handshake SHALL load the 8-bit beat counter with ARLEN (zero-extended) and enter DATA.
REQ-021 In DATA, M_R* SHALL route to the granted Sx_R*, M_RREADY SHALL equal Sx_RREADY, and the non-granted Sn_RVALID SHALL be 0.
REQ-022 Each DATA beat handshake SHALL decrement the counter; the counter SHALL never wrap below 0.
REQ-023 On the M_RLAST handshake, SHALL return to IDLE; the minimum gap between bursts is 1 IDLE cycle.
REQ-024 SHALL set PROT_ERR if M_RLAST arrives with counter≠0, or if counter=0 and a beat arrives without RLAST; PROT_ERR clears only on reset.
REQ-025 Outside DATA, M_RREADY SHALL be 0 and all Sn_RVALID SHALL be 0; outside ADDR, M_ARVALID and all Sn_ARREADY SHALL be 0.

Reset
REQ-026 With nRST=0 at an edge, SHALL force IDLE, counter 0, GRANT 1, PROT_ERR 0.
REQ-027 Reset mid-burst SHALL abandon the burst with no further beats forwarded; all handshake outputs SHALL be 0 in the reset cycle.

Configuration
REQ-028 With macro ARB_FIXED_PRIORITY_EN defined, S0 SHALL always win a simultaneous request and GRANT history SHALL be ignored.
REQ-029 Without ARB_FIXED_PRIORITY_EN, the round-robin rule of REQ-017 SHALL apply.

Verification
REQ-030 S0 ARADDR=0x1000, ARLEN=3 alone, M_ARREADY=1 -> M_ARVALID 1 cycle after the request, 4 beats on S0, S1_RVALID=0 throughout, then IDLE.
REQ-031 S0 and S1 valid together for 3 bursts each with ARLEN=0 -> grant order S0,S1,S0,S1,S0,S1 (with the macro defined: S0×3 then S1×3).
REQ-032 Sx_RREADY held 0 for 5 cycles mid-burst -> M_RREADY=0, data held, no beat lost, counter unchanged.
REQ-033 ARLEN=1 but slave asserts RLAST on beat 0 -> PROT_ERR=1 on the next cycle and stays 1; FSM returns to IDLE.
REQ-034 nRST=0 during beat 2 of an ARLEN=7 burst -> next cycle IDLE, GRANT=1, all VALID/READY outputs 0.
REQ-035 M_ARREADY held 0 for 10 cycles -> FSM stays in ADDR, M_AR* stable, GRANT unchanged although the other requester is valid.
